// File: rtl/depipe_pkg.sv
// depipe_pkg: shared widths and the packed control bundle for the
// Decode->Execute pipeline register. The optional branch/flag control bits
// are present only when DEPIPE_BRANCH_EN is defined.
package depipe_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ALUCTRL_W = 3;
    localparam int unsigned REGIDX_W  = 4;

    // Control bundle carried from Decode into Execute.
    typedef struct packed {
        logic                 regw;
        logic                 memw;
        logic                 regmem;
        logic                 ALUope;
        logic [ALUCTRL_W-1:0] ALUctrl;
`ifdef DEPIPE_BRANCH_EN
        logic                 branch;
        logic                 flag;
`endif
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    // A control word is a no-op when it writes neither the register file
    // nor memory; the all-zero bubble always satisfies this.
    function automatic logic ctrl_is_noop(input ctrl_t c);
        return (c.regw == 1'b0) && (c.memw == 1'b0);
    endfunction

endpackage : depipe_pkg

// File: rtl/depipe_pipe_reg.sv
// pipe_reg: generic WIDTH-bit pipeline register with asynchronous active-low
// reset and a synchronous flush that loads an all-zero bubble.
// Priority: rst_n low > flush > capture of d.
module pipe_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage register: async clear, sync bubble on flush, otherwise capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {WIDTH{1'b0}};
        end else if (flush) begin
            q <= {WIDTH{1'b0}};
        end else begin
            q <= d;
        end
    end

endmodule : pipe_reg

// File: rtl/depipe.sv
// depipe: Decode->Execute pipeline register. Every _E output is the registered
// copy of its _D input (one cycle latency); flush_E inserts an all-zero
// bubble, rst_n clears everything asynchronously. Data passes bit-exact.
// Optional feature macro: DEPIPE_BRANCH_EN adds branch_D/flag_D and
// branch_E/flag_E, registered exactly like the other control bits.
module depipe
    import depipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_E,
    input  logic                 regw_D,
    input  logic                 memw_D,
    input  logic                 regmem_D,
    input  logic                 ALUope_D,
    input  logic [ALUCTRL_W-1:0] ALUctrl_D,
    input  logic [REGIDX_W-1:0]  regScr_D,
    input  logic [DATA_W-1:0]    regA_D,
    input  logic [DATA_W-1:0]    regB_D,
    input  logic [DATA_W-1:0]    inm_D,
`ifdef DEPIPE_BRANCH_EN
    input  logic                 branch_D,
    input  logic                 flag_D,
    output logic                 branch_E,
    output logic                 flag_E,
`endif
    output logic                 regw_E,
    output logic                 memw_E,
    output logic                 regmem_E,
    output logic                 ALUope_E,
    output logic [ALUCTRL_W-1:0] ALUctrl_E,
    output logic [REGIDX_W-1:0]  regScr_E,
    output logic [DATA_W-1:0]    regA_E,
    output logic [DATA_W-1:0]    regB_E,
    output logic [DATA_W-1:0]    inm_E
);

    ctrl_t               ctrl_d;
    ctrl_t               ctrl_q;
    logic [REGIDX_W-1:0] regscr_q;

    // Gather the Decode control inputs into the packed control bundle.
    always_comb begin
        ctrl_d         = '{default: 1'b0};
        ctrl_d.regw    = regw_D;
        ctrl_d.memw    = memw_D;
        ctrl_d.regmem  = regmem_D;
        ctrl_d.ALUope  = ALUope_D;
        ctrl_d.ALUctrl = ALUctrl_D;
`ifdef DEPIPE_BRANCH_EN
        ctrl_d.branch  = branch_D;
        ctrl_d.flag    = flag_D;
`endif
    end

    pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_E),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    pipe_reg #(.WIDTH(REGIDX_W)) u_regscr_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_E),
        .d     (regScr_D),
        .q     (regscr_q)
    );

    pipe_reg #(.WIDTH(DATA_W)) u_rega_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_E),
        .d     (regA_D),
        .q     (regA_E)
    );

    pipe_reg #(.WIDTH(DATA_W)) u_regb_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_E),
        .d     (regB_D),
        .q     (regB_E)
    );

    pipe_reg #(.WIDTH(DATA_W)) u_inm_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_E),
        .d     (inm_D),
        .q     (inm_E)
    );

    // Outputs are direct taps of the stage registers; no logic follows them.
    assign regw_E    = ctrl_q.regw;
    assign memw_E    = ctrl_q.memw;
    assign regmem_E  = ctrl_q.regmem;
    assign ALUope_E  = ctrl_q.ALUope;
    assign ALUctrl_E = ctrl_q.ALUctrl;
    assign regScr_E  = regscr_q;
`ifdef DEPIPE_BRANCH_EN
    assign branch_E  = ctrl_q.branch;
    assign flag_E    = ctrl_q.flag;
`endif

endmodule : depipe

// File: tb/tb_depipe.sv
// tb_depipe: directed self-checking bench for depipe. Build with
// DEPIPE_BRANCH_EN defined to also exercise the branch/flag bits.
`timescale 1ns/1ps
module tb_depipe;

    logic        clk;
    logic        rst_n;
    logic        flush_E;
    logic        regw_D, memw_D, regmem_D, ALUope_D;
    logic [2:0]  ALUctrl_D;
    logic [3:0]  regScr_D;
    logic [31:0] regA_D, regB_D, inm_D;
    logic        regw_E, memw_E, regmem_E, ALUope_E;
    logic [2:0]  ALUctrl_E;
    logic [3:0]  regScr_E;
    logic [31:0] regA_E, regB_E, inm_E;
    logic        br_d, fl_d;
    logic        br_e, fl_e;

    int errors_cnt;
    int checks_cnt;

`ifdef DEPIPE_BRANCH_EN
    logic branch_E, flag_E;
    assign br_e = branch_E;
    assign fl_e = flag_E;
`else
    assign br_e = 1'b0;
    assign fl_e = 1'b0;
`endif

    depipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_E   (flush_E),
        .regw_D    (regw_D),
        .memw_D    (memw_D),
        .regmem_D  (regmem_D),
        .ALUope_D  (ALUope_D),
        .ALUctrl_D (ALUctrl_D),
        .regScr_D  (regScr_D),
        .regA_D    (regA_D),
        .regB_D    (regB_D),
        .inm_D     (inm_D),
`ifdef DEPIPE_BRANCH_EN
        .branch_D  (br_d),
        .flag_D    (fl_d),
        .branch_E  (branch_E),
        .flag_E    (flag_E),
`endif
        .regw_E    (regw_E),
        .memw_E    (memw_E),
        .regmem_E  (regmem_E),
        .ALUope_E  (ALUope_E),
        .ALUctrl_E (ALUctrl_E),
        .regScr_E  (regScr_E),
        .regA_E    (regA_E),
        .regB_E    (regB_E),
        .inm_E     (inm_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack one output word: {19'b0, br, fl, regw, memw, regmem, ALUope, ALUctrl, regScr, A, B, inm}.
    function automatic logic [127:0] mk(input logic rw, input logic mw, input logic rm,
                                        input logic ao, input logic [2:0] ac,
                                        input logic [3:0] rs, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] im,
                                        input logic br, input logic fl);
        return {19'd0, br, fl, rw, mw, rm, ao, ac, rs, a, b, im};
    endfunction

    function automatic logic [127:0] obs_vec();
        return mk(regw_E, memw_E, regmem_E, ALUope_E, ALUctrl_E, regScr_E,
                  regA_E, regB_E, inm_E, br_e, fl_e);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mw, input logic rm, input logic ao,
                         input logic [2:0] ac, input logic [3:0] rs, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im,
                         input logic br, input logic fl);
        regw_D = rw; memw_D = mw; regmem_D = rm; ALUope_D = ao;
        ALUctrl_D = ac; regScr_D = rs; regA_D = a; regB_D = b; inm_D = im;
        br_d = br; fl_d = fl;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] zero_v, v1, v2, v3, ones_v;
    logic         brx;

    initial begin
        errors_cnt = 0;
        checks_cnt = 0;
`ifdef DEPIPE_BRANCH_EN
        brx = 1'b1;
`else
        brx = 1'b0;
`endif
        zero_v = 128'd0;
        v1     = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 4'b0011, 32'h0000FFFF, 32'h00000801, 32'h00000000, 1'b0, 1'b0);
        v2     = mk(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 4'b0100, 32'h0000FFFF, 32'h00000000, 32'h00000401, 1'b0, 1'b0);
        v3     = mk(1'b0, 1'b1, 1'b1, 1'b0, 3'b110, 4'b1010, 32'hA5A55A5A, 32'h80000001, 32'hFFFC0000, brx, brx);
        ones_v = mk(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, brx, brx);

        // Reset with all inputs high: outputs clear before any clock edge.
        rst_n = 1'b1;
        flush_E = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("reset_async", obs_vec(), zero_v);
        tick();
        check("reset_held", obs_vec(), zero_v);

        // First edge after release with all-ones inputs captures them.
        rst_n = 1'b1;
        flush_E = 1'b0;
        tick();
        check("post_reset_capture", obs_vec(), ones_v);

        // Capture vector: not visible before the edge, visible after.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 4'b0011, 32'h0000FFFF, 32'h00000801, 32'h00000000, 1'b0, 1'b0);
        #2 check("hold_before_edge", obs_vec(), ones_v);
        tick();
        check("capture_v1", obs_vec(), v1);

        // Back-to-back vector; output holds v1 until the edge.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 4'b0100, 32'h0000FFFF, 32'h00000000, 32'h00000401, 1'b0, 1'b0);
        #2 check("no_comb_path", obs_vec(), v1);
        tick();
        check("back_to_back_v2", obs_vec(), v2);

        // Flush held for three edges, inputs unchanged.
        flush_E = 1'b1;
        #2 check("flush_not_early", obs_vec(), v2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("flush_edge%0d", i), obs_vec(), zero_v);
        end
        check("bubble_noop", {127'd0, (regw_E | memw_E)}, 128'd0);
        flush_E = 1'b0;
        tick();
        check("flush_release_capture", obs_vec(), v2);

        // Asynchronous reset pulse between edges while outputs are nonzero.
        #2 rst_n = 1'b0;
        #1 check("async_mid_stream", obs_vec(), zero_v);
        #2 rst_n = 1'b1;
        #2 check("zero_until_edge", obs_vec(), zero_v);
        tick();
        check("after_reset_capture", obs_vec(), v2);

        // Reset during flush, then flush wins at the first edge after release.
        flush_E = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_during_flush", obs_vec(), zero_v);
        rst_n = 1'b1;
        tick();
        check("post_reset_flush", obs_vec(), zero_v);
        flush_E = 1'b0;

        // Bit-exact data with sign-like patterns; branch/flag set when present.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b110, 4'b1010, 32'hA5A55A5A, 32'h80000001, 32'hFFFC0000, 1'b1, 1'b1);
        tick();
        check("bit_exact_v3", obs_vec(), v3);
`ifdef DEPIPE_BRANCH_EN
        check("branch_flag_set", {126'd0, branch_E, flag_E}, {126'd0, 2'b11});
        flush_E = 1'b1;
        tick();
        check("branch_flag_flush", {126'd0, branch_E, flag_E}, 128'd0);
        flush_E = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule : tb_depipe
